// File: rtl/inst_cycle_ctrl.sv
// Multi-cycle instruction sequencer: owns the PC and steps each instruction
// through FETCH/WAIT/DECODE/EXEC/WB with a fetch handshake, halt and trap states.
module inst_cycle_ctrl #(
    parameter logic [31:0] PC_RESET = 32'h80000000,
    parameter logic [7:0]  TIMEOUT  = 8'd255,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run_en,
    output logic             ifu_req,
    output logic [31:0]      ifu_addr,
    input  logic             ifu_rvalid,
    input  logic [31:0]      ifu_rdata,
    output logic [31:0]      inst_q,
    output logic [31:0]      pc,
    output logic             rf_wen,
    output logic             pc_wen,
    output logic [2:0]       state,
    output logic             halted,
    output logic             err,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_WAIT   = 3'd2,
        S_DECODE = 3'd3,
        S_EXEC   = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_ERR    = 3'd7
    } state_t;

    state_t           state_reg, state_next;
    logic [31:0]      pc_reg;
    logic [31:0]      inst_reg;
    logic [7:0]       wait_cnt_reg;
    logic [CNT_W-1:0] instret_reg;
    logic             halted_reg;
    logic             err_reg;
    logic [1:0]       err_code_reg;

    logic is_ebreak;
    logic is_addi;
    logic wait_expired;

    assign is_ebreak    = (inst_reg == 32'h00100073);
    assign is_addi      = (inst_reg[6:0] == 7'b0010011) && (inst_reg[14:12] == 3'b000);
    assign wait_expired = !ifu_rvalid && (wait_cnt_reg == TIMEOUT);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:   if (run_en) state_next = S_FETCH;
            S_FETCH:  state_next = S_WAIT;
            S_WAIT: begin
                if (ifu_rvalid)        state_next = S_DECODE;
                else if (wait_expired) state_next = S_ERR;
            end
            S_DECODE: begin
                if (is_ebreak)    state_next = S_HALT;
                else if (is_addi) state_next = S_EXEC;
                else              state_next = S_ERR;
            end
            S_EXEC:   state_next = S_WB;
            S_WB:     state_next = run_en ? S_FETCH : S_IDLE;
            S_HALT:   state_next = S_HALT;
            S_ERR:    state_next = S_ERR;
            default:  state_next = S_IDLE;
        endcase
    end

    // Datapath registers only change in the state that owns them, so HALT/ERR freeze everything.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_reg       <= PC_RESET;
            inst_reg     <= 32'd0;
            wait_cnt_reg <= 8'd0;
            instret_reg  <= '0;
            halted_reg   <= 1'b0;
            err_reg      <= 1'b0;
            err_code_reg <= 2'd0;
        end else begin
            case (state_reg)
                S_FETCH: wait_cnt_reg <= 8'd0;
                S_WAIT: begin
                    if (ifu_rvalid) begin
                        inst_reg     <= ifu_rdata;
                        wait_cnt_reg <= 8'd0;
                    end else if (wait_expired) begin
                        err_reg      <= 1'b1;
                        err_code_reg <= 2'd1;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 8'd1;
                    end
                end
                S_DECODE: begin
                    if (is_ebreak) begin
                        halted_reg  <= 1'b1;
                        instret_reg <= instret_reg + {{(CNT_W-1){1'b0}}, 1'b1};
                    end else if (!is_addi) begin
                        err_reg      <= 1'b1;
                        err_code_reg <= 2'd2;
                    end
                end
                S_WB: begin
                    pc_reg      <= pc_reg + 32'd4;
                    instret_reg <= instret_reg + {{(CNT_W-1){1'b0}}, 1'b1};
                end
                default: ;
            endcase
        end
    end

    assign state    = state_reg;
    assign ifu_req  = (state_reg == S_FETCH);
    assign ifu_addr = pc_reg;
    assign inst_q   = inst_reg;
    assign pc       = pc_reg;
    assign rf_wen   = (state_reg == S_WB) && (inst_reg[11:7] != 5'd0);
    assign pc_wen   = (state_reg == S_WB);
    assign halted   = halted_reg;
    assign err      = err_reg;
    assign err_code = err_code_reg;
    assign instret  = instret_reg;

endmodule
